pifo_reg_evict: RTL
===================

// Module: pifo_reg_evict
// PURPOSE
//   Parametrised register-based PIFO: shallow sorted-dequeue store with valid/ready handshakes,
//   FIFO tie-break among equal ranks and a selectable overflow policy.
//   When full, it can evict the largest rank; every discarded element is reported on an evict port.
//   Sits between the rank-computation stage and the output scheduler in the SUME switch datapath.
// PARAMETERS
//   L2_DEPTH    2   log2 of entry count; DEPTH = 2**L2_DEPTH (range 1..5)
//   RANK_WIDTH  8   rank width; unsigned, smaller = higher priority
//   META_WIDTH  8   metadata width carried with each rank
//   OVF_MODE    0   0 = reject when full (backpressure); 1 = evict-max when full
//   CNT_WIDTH   16  width of saturating drop counter
// PORTS
//   clk           in   1           clock
//   rst_n         in   1           reset; asynchronous, active-low
//   ins_valid     in   1           insert request
//   ins_ready     out  1           insert accepted when ins_valid & ins_ready at posedge
//   ins_rank      in   RANK_WIDTH  rank to insert
//   ins_meta      in   META_WIDTH  metadata to insert
//   deq_valid     out  1           head (min) element valid
//   deq_ready     in   1           consumer takes head when deq_valid & deq_ready
//   deq_rank      out  RANK_WIDTH  head rank (registered)
//   deq_meta      out  META_WIDTH  head metadata (registered)
//   evict_valid   out  1           one-cycle pulse: an element was discarded
//   evict_rank    out  RANK_WIDTH  discarded rank
//   evict_meta    out  META_WIDTH  discarded metadata
//   drop_cnt      out  CNT_WIDTH   saturating count of discards
//   num_entries   out  L2_DEPTH+1  occupancy
//   empty         out  1           num_entries == 0
//   full          out  1           num_entries == DEPTH
// BEHAVIOUR
// - Reset (rst_n low, async): entry valid bits, num_entries, drop_cnt = 0.
//   deq_valid, evict_valid, full = 0; deq_rank/meta, evict_rank/meta = 0; empty = 1.
//   Rank/meta storage is not cleared. Outputs change without waiting for clk.
// - Storage is compacted in arrival order: slot 0 is oldest; valid slots are 0..num_entries-1.
// - Combinational min tree over valid slots; ties pick the lower index, so equal ranks dequeue FIFO.
//   Max tree ties pick the higher index (newest).
// - ins_ready = 1 when OVF_MODE=1; otherwise !full.
//   No combinational path from ins_valid or deq_ready to ins_ready.
// - Dequeue fire: remove the min slot, shift higher slots down by one, num_entries-1.
// - Insert fire, not full: append at slot num_entries, num_entries+1.
// - Simultaneous insert and dequeue: both are accepted.
//   Min is removed; new element appended at the compacted end; num_entries unchanged; no eviction even if full.
// - Insert fire when full, no dequeue (OVF_MODE=1 only):
//     ins_rank < max rank: evict the max slot, shift down above it, append new at DEPTH-1.
//     ins_rank >= max rank: the new element is discarded; storage unchanged.
//   In both cases, next cycle: evict_valid=1 carrying the discarded element; drop_cnt+1, saturating at all-ones.
// - Head pipeline: deq_rank/meta registered from the min tree.
//   Any fired insert/dequeue at edge N clears deq_valid after edge N.
//   At edge N+1, head is relatched; deq_valid = (num_entries>0) if no new op fired at N+1.
//   Therefore: insert-to-deq_valid latency 2 edges; max dequeue rate one per 2 cycles.
// - deq_ready without deq_valid has no effect.
// - evict_valid is high exactly one cycle per discard; evict_rank/meta hold their last value otherwise.
// - empty/full/num_entries update on the edge of the causing fire.
// TESTING
// 1. rst_n=0 mid-stream -> immediately empty=1, deq_valid=0, num_entries=0, drop_cnt=0, ins_ready=1.
// 2. DEPTH=4: insert (5,A),(3,B),(7,C),(3,D) -> full=1.
//    Dequeues return 3/B, 3/D, 5/A, 7/C, then empty=1.
// 3. OVF_MODE=1, full {5,3,7,3}: insert (4,E) -> evict 7/C 1 cycle, num_entries=4.
//    Insert (9,F) -> evict 9/F, drop_cnt=2.
// 4. OVF_MODE=0, full: ins_ready=0; ins_valid held -> no state change, evict_valid stays 0.
// 5. Full {5,3,7,3}, same-cycle dequeue + insert (1,G) -> output 3/B, num_entries=4, next head 1/G, no evict.
// 6. Single insert (2,H) at edge N -> deq_valid low after N, high after N+1 with 2/H.
//    Dequeue -> empty=1, deq_valid stays 0.

Source files
------------

// File: rtl/pifo_reg_evict.sv
// Register-based PIFO: arrival-ordered compacted storage, min-rank dequeue with FIFO tie-break,
// optional evict-max overflow policy with discard reporting and saturating drop counter.
module pifo_reg_evict #(
    parameter int unsigned L2_DEPTH   = 2,
    parameter int unsigned RANK_WIDTH = 8,
    parameter int unsigned META_WIDTH = 8,
    parameter int unsigned OVF_MODE   = 0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    input  logic [RANK_WIDTH-1:0] ins_rank,
    input  logic [META_WIDTH-1:0] ins_meta,
    output logic                  deq_valid,
    input  logic                  deq_ready,
    output logic [RANK_WIDTH-1:0] deq_rank,
    output logic [META_WIDTH-1:0] deq_meta,
    output logic                  evict_valid,
    output logic [RANK_WIDTH-1:0] evict_rank,
    output logic [META_WIDTH-1:0] evict_meta,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic [L2_DEPTH:0]     num_entries,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned DEPTH = 1 << L2_DEPTH;

    typedef logic [L2_DEPTH-1:0] idx_t;
    typedef logic [L2_DEPTH:0]   cnt_t;

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    logic [RANK_WIDTH-1:0] rank_q [DEPTH];
    logic [RANK_WIDTH-1:0] rank_n [DEPTH];
    logic [META_WIDTH-1:0] meta_q [DEPTH];
    logic [META_WIDTH-1:0] meta_n [DEPTH];
    cnt_t                  cnt_q;
    cnt_t                  cnt_n;

    logic                  ins_fire;
    logic                  deq_fire;

    idx_t                  min_idx;
    idx_t                  max_idx;
    logic [RANK_WIDTH-1:0] min_rank;
    logic [RANK_WIDTH-1:0] max_rank;
    logic [META_WIDTH-1:0] min_meta;
    logic [META_WIDTH-1:0] max_meta;

    logic                  do_remove;
    logic                  do_append;
    idx_t                  rm_idx;
    idx_t                  app_idx;
    logic                  ev_fire;
    logic [RANK_WIDTH-1:0] ev_rank;
    logic [META_WIDTH-1:0] ev_meta;

    assign num_entries = cnt_q;
    assign empty       = (cnt_q == '0);
    assign full        = (cnt_q == FULL_CNT);
    assign ins_ready   = (OVF_MODE != 0) || !full;
    assign ins_fire    = ins_valid && ins_ready;
    assign deq_fire    = deq_valid && deq_ready;

    // Strict '<' keeps the oldest of equal minima; '>=' moves the max to the newest of equals.
    always_comb begin
        min_idx  = '0;
        min_rank = rank_q[0];
        min_meta = meta_q[0];
        max_idx  = '0;
        max_rank = rank_q[0];
        max_meta = meta_q[0];
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (i < 32'(cnt_q)) begin
                if (rank_q[i] < min_rank) begin
                    min_idx  = idx_t'(i);
                    min_rank = rank_q[i];
                    min_meta = meta_q[i];
                end
                if (rank_q[i] >= max_rank) begin
                    max_idx  = idx_t'(i);
                    max_rank = rank_q[i];
                    max_meta = meta_q[i];
                end
            end
        end
    end

    always_comb begin
        do_remove = 1'b0;
        do_append = 1'b0;
        rm_idx    = min_idx;
        app_idx   = idx_t'(cnt_q);
        cnt_n     = cnt_q;
        ev_fire   = 1'b0;
        ev_rank   = max_rank;
        ev_meta   = max_meta;
        if (deq_fire) begin
            do_remove = 1'b1;
            if (ins_fire) begin
                do_append = 1'b1;
                app_idx   = idx_t'(cnt_q - cnt_t'(1));
            end else begin
                cnt_n = cnt_q - cnt_t'(1);
            end
        end else if (ins_fire) begin
            if (!full) begin
                do_append = 1'b1;
                cnt_n     = cnt_q + cnt_t'(1);
            end else begin
                ev_fire = 1'b1;
                if (ins_rank < max_rank) begin
                    do_remove = 1'b1;
                    rm_idx    = max_idx;
                    do_append = 1'b1;
                    app_idx   = idx_t'(DEPTH - 1);
                end else begin
                    ev_rank = ins_rank;
                    ev_meta = ins_meta;
                end
            end
        end
    end

    // Removal closes the gap by shifting newer entries down; the append then lands on the compacted end.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rank_n[i] = rank_q[i];
            meta_n[i] = meta_q[i];
        end
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            if (do_remove && (i >= 32'(rm_idx))) begin
                rank_n[i] = rank_q[i+1];
                meta_n[i] = meta_q[i+1];
            end
        end
        if (do_append) begin
            rank_n[app_idx] = ins_rank;
            meta_n[app_idx] = ins_meta;
        end
    end

    always_ff @(posedge clk) begin
        rank_q <= rank_n;
        meta_q <= meta_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            deq_valid   <= 1'b0;
            deq_rank    <= '0;
            deq_meta    <= '0;
            evict_valid <= 1'b0;
            evict_rank  <= '0;
            evict_meta  <= '0;
            drop_cnt    <= '0;
        end else begin
            cnt_q       <= cnt_n;
            evict_valid <= ev_fire;
            if (ev_fire) begin
                evict_rank <= ev_rank;
                evict_meta <= ev_meta;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
            // Head is only relatched on a quiet edge, so it always reflects settled storage.
            if (ins_fire || deq_fire) begin
                deq_valid <= 1'b0;
            end else begin
                deq_valid <= (cnt_q != '0);
                deq_rank  <= min_rank;
                deq_meta  <= min_meta;
            end
        end
    end

endmodule
